// File: rtl/processador_multiciclo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : processador_multiciclo_pkg
//  Description : Shared constants for the multicycle processor: data and
//                instruction widths, opcode encodings and the step type.
//  Revision    : 1.0 - initial release
// ============================================================================
package processador_multiciclo_pkg;

   localparam int DATA_W = 16;
   localparam int IR_W   = 9;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MVNZ = 3'b100;

   // Execution step; T0 is fetch, T1..T3 are execute steps.
   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } tstep_t;

endpackage
`default_nettype wire

// File: rtl/processador_multiciclo_regn.sv
`default_nettype none
// ============================================================================
//  Module      : regn
//  Description : N-bit datapath register. Captures on the falling edge of
//                Clock so the value driven on the bus during a step is
//                stored in the middle of that step.
//  Ports       : Clock - system clock
//                Clear - synchronous clear (priority over En)
//                En    - load enable
//                D     - data in
//                Q     - registered data out
//  Revision    : 1.0 - initial release
// ============================================================================
module regn #(
   parameter int N = 16
) (
   input  logic         Clock,
   input  logic         Clear,
   input  logic         En,
   input  logic [N-1:0] D,
   output logic [N-1:0] Q
);

   always_ff @(negedge Clock) begin
      if (Clear) begin
         Q <= '0;
      end else if (En) begin
         Q <= D;
      end
   end

endmodule
`default_nettype wire

// File: rtl/processador_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : processador_multiciclo
//  Description : Multicycle 16-bit processor with R0-R7, accumulator A,
//                result register G, 9-bit IR and one shared bus.
//  Ports       : Clock    - system clock
//                Resetn   - synchronous active-high reset
//                DIN      - instruction word (T0) / immediate (mvi T1)
//                Run      - start an instruction when in T0
//                Done     - high in the final step of an instruction
//                BusWires - shared bus value
//                Rx_data  - register selected by IR[5:3]
//                Ry_data  - register selected by IR[2:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module processador_multiciclo
   import processador_multiciclo_pkg::*;
(
   input  logic              Clock,
   input  logic              Resetn,
   input  logic [DATA_W-1:0] DIN,
   input  logic              Run,
   output logic              Done,
   output logic [DATA_W-1:0] BusWires,
   output logic [DATA_W-1:0] Rx_data,
   output logic [DATA_W-1:0] Ry_data
);

   tstep_t            r_tstep;
   tstep_t            w_tstep_next;
   // Reset seen at the rising edge, applied to the datapath at the next
   // falling edge so every register clears in the same step.
   logic              r_clr;

   logic [IR_W-1:0]   w_ir;
   logic [DATA_W-1:0] w_r [0:7];
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_g;
   logic [DATA_W-1:0] w_alu;
   logic [2:0]        w_op;
   logic [2:0]        w_x;
   logic [2:0]        w_y;
   logic              w_irin;
   logic              w_ain;
   logic              w_gin;
   logic              w_rxin;
   logic [7:0]        w_rin;

   assign w_op    = w_ir[8:6];
   assign w_x     = w_ir[5:3];
   assign w_y     = w_ir[2:0];
   assign Rx_data = w_r[w_x];
   assign Ry_data = w_r[w_y];
   assign w_rin   = w_rxin ? (8'b1 << w_x) : 8'b0;
   assign w_alu   = (w_op == OP_SUB) ? (w_a - BusWires) : (w_a + BusWires);

   always_ff @(posedge Clock) begin
      r_clr <= Resetn;
      if (Resetn) begin
         r_tstep <= T0;
      end else begin
         r_tstep <= w_tstep_next;
      end
   end

   always_comb begin
      w_irin   = 1'b0;
      w_ain    = 1'b0;
      w_gin    = 1'b0;
      w_rxin   = 1'b0;
      Done     = 1'b0;
      BusWires = '0;
      case (r_tstep)
         T0: w_irin = Run;
         T1: begin
            case (w_op)
               OP_MV: begin
                  BusWires = w_r[w_y];
                  w_rxin   = 1'b1;
                  Done     = 1'b1;
               end
               OP_MVI: begin
                  BusWires = DIN;
                  w_rxin   = 1'b1;
                  Done     = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  BusWires = w_r[w_x];
                  w_ain    = 1'b1;
               end
               OP_MVNZ: begin
                  if (w_g != '0) begin
                     BusWires = w_r[w_y];
                     w_rxin   = 1'b1;
                  end
                  Done = 1'b1;
               end
               default: Done = 1'b1;
            endcase
         end
         T2: begin
            if (w_op == OP_ADD || w_op == OP_SUB) begin
               BusWires = w_r[w_y];
               w_gin    = 1'b1;
            end else begin
               // Unreachable for a single-step opcode; return to fetch.
               Done = 1'b1;
            end
         end
         default: begin
            if (w_op == OP_ADD || w_op == OP_SUB) begin
               BusWires = w_g;
               w_rxin   = 1'b1;
            end
            Done = 1'b1;
         end
      endcase

      if (Done) begin
         w_tstep_next = T0;
      end else if (r_tstep == T0 && !Run) begin
         w_tstep_next = T0;
      end else begin
         w_tstep_next = tstep_t'(r_tstep + 2'd1);
      end
   end

   regn #(.N(IR_W))   IR (.Clock(Clock), .Clear(r_clr), .En(w_irin),   .D(DIN[IR_W-1:0]), .Q(w_ir));
   regn #(.N(DATA_W)) A  (.Clock(Clock), .Clear(r_clr), .En(w_ain),    .D(BusWires),      .Q(w_a));
   regn #(.N(DATA_W)) G  (.Clock(Clock), .Clear(r_clr), .En(w_gin),    .D(w_alu),         .Q(w_g));
   regn #(.N(DATA_W)) R0 (.Clock(Clock), .Clear(r_clr), .En(w_rin[0]), .D(BusWires),      .Q(w_r[0]));
   regn #(.N(DATA_W)) R1 (.Clock(Clock), .Clear(r_clr), .En(w_rin[1]), .D(BusWires),      .Q(w_r[1]));
   regn #(.N(DATA_W)) R2 (.Clock(Clock), .Clear(r_clr), .En(w_rin[2]), .D(BusWires),      .Q(w_r[2]));
   regn #(.N(DATA_W)) R3 (.Clock(Clock), .Clear(r_clr), .En(w_rin[3]), .D(BusWires),      .Q(w_r[3]));
   regn #(.N(DATA_W)) R4 (.Clock(Clock), .Clear(r_clr), .En(w_rin[4]), .D(BusWires),      .Q(w_r[4]));
   regn #(.N(DATA_W)) R5 (.Clock(Clock), .Clear(r_clr), .En(w_rin[5]), .D(BusWires),      .Q(w_r[5]));
   regn #(.N(DATA_W)) R6 (.Clock(Clock), .Clear(r_clr), .En(w_rin[6]), .D(BusWires),      .Q(w_r[6]));
   regn #(.N(DATA_W)) R7 (.Clock(Clock), .Clear(r_clr), .En(w_rin[7]), .D(BusWires),      .Q(w_r[7]));

endmodule
`default_nettype wire

// File: tb/tb_processador_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_processador_multiciclo
//  Description : Self-checking bench for processador_multiciclo. An
//                instruction-level model predicts bus/Done per step and the
//                architectural state after each instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_processador_multiciclo;

   localparam logic [2:0] c_mv   = 3'b000;
   localparam logic [2:0] c_mvi  = 3'b001;
   localparam logic [2:0] c_add  = 3'b010;
   localparam logic [2:0] c_sub  = 3'b011;
   localparam logic [2:0] c_mvnz = 3'b100;
   localparam logic [2:0] c_nop  = 3'b110;

   logic        Clock;
   logic        Resetn;
   logic [15:0] DIN;
   logic        Run;
   logic        Done;
   logic [15:0] BusWires;
   logic [15:0] Rx_data;
   logic [15:0] Ry_data;

   int checks = 0;
   int errors = 0;

   // Expected per-step outputs, set by the driver, checked by the compare process.
   logic        exp_valid = 1'b0;
   logic [15:0] exp_bus;
   logic        exp_done;
   logic        exp_rxy;
   logic [15:0] exp_rx;
   logic [15:0] exp_ry;

   // Architectural model.
   logic [15:0] m_r [0:7];
   logic [15:0] m_a;
   logic [15:0] m_g;

   processador_multiciclo dut (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .DIN     (DIN),
      .Run     (Run),
      .Done    (Done),
      .BusWires(BusWires),
      .Rx_data (Rx_data),
      .Ry_data (Ry_data)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Compare process: sampled mid-step, before the falling-edge write.
   always begin
      @(posedge Clock);
      #4;
      if (exp_valid) begin
         chk("bus", BusWires, exp_bus);
         chk("done", {15'd0, Done}, {15'd0, exp_done});
         if (exp_rxy) begin
            chk("rx_data", Rx_data, exp_rx);
            chk("ry_data", Ry_data, exp_ry);
         end
      end
   end

   function automatic logic [15:0] dut_reg(input int i);
      case (i)
         0: return dut.R0.Q;
         1: return dut.R1.Q;
         2: return dut.R2.Q;
         3: return dut.R3.Q;
         4: return dut.R4.Q;
         5: return dut.R5.Q;
         6: return dut.R6.Q;
         default: return dut.R7.Q;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
      m_a = 16'd0;
      m_g = 16'd0;
   endtask

   task automatic check_state();
      for (int i = 0; i < 8; i++) chk($sformatf("R%0d", i), dut_reg(i), m_r[i]);
      chk("A", dut.A.Q, m_a);
      chk("G", dut.G.Q, m_g);
   endtask

   // One clock step: called at posedge+1, returns at the next posedge+1.
   task automatic step(input logic [15:0] a_din, input logic a_run,
                       input logic [15:0] e_bus, input logic e_done,
                       input logic e_rxy, input logic [15:0] e_rx, input logic [15:0] e_ry);
      DIN       = a_din;
      Run       = a_run;
      exp_bus   = e_bus;
      exp_done  = e_done;
      exp_rxy   = e_rxy;
      exp_rx    = e_rx;
      exp_ry    = e_ry;
      exp_valid = 1'b1;
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      step(16'h01FF, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
      chk("tstep_idle", 16'(dut.r_tstep), 16'd0);
   endtask

   task automatic exec(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                       input logic [15:0] imm);
      logic [8:0]  ir;
      logic [15:0] rx;
      logic [15:0] ry;
      logic [15:0] res;
      ir = {op, x, y};
      rx = m_r[x];
      ry = m_r[y];
      step({7'd0, ir}, 1'b1, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
      chk("IR", {7'd0, dut.IR.Q}, {7'd0, ir});
      case (op)
         c_mv: begin
            step(16'd0, 1'b0, ry, 1'b1, 1'b1, rx, ry);
            m_r[x] = ry;
         end
         c_mvi: begin
            step(imm, 1'b0, imm, 1'b1, 1'b1, rx, ry);
            m_r[x] = imm;
         end
         c_add, c_sub: begin
            res = (op == c_add) ? rx + ry : rx - ry;
            step(16'd0, 1'b0, rx, 1'b0, 1'b1, rx, ry);
            step(16'd0, 1'b0, ry, 1'b0, 1'b1, rx, ry);
            step(16'd0, 1'b0, res, 1'b1, 1'b1, rx, ry);
            m_a    = rx;
            m_g    = res;
            m_r[x] = res;
         end
         c_mvnz: begin
            step(16'd0, 1'b0, (m_g != 16'd0) ? ry : 16'd0, 1'b1, 1'b1, rx, ry);
            if (m_g != 16'd0) m_r[x] = ry;
         end
         default: begin
            step(16'd0, 1'b0, 16'd0, 1'b1, 1'b1, rx, ry);
         end
      endcase
      chk("tstep_after", 16'(dut.r_tstep), 16'd0);
      check_state();
   endtask

   initial begin
      Resetn = 1'b1;
      Run    = 1'b0;
      DIN    = 16'd0;
      model_reset();
      repeat (3) @(posedge Clock);
      #1;
      Resetn = 1'b0;

      // Reset state and idle hold.
      idle();
      check_state();
      idle();
      idle();

      // mv R0,R1 with R0=11, R1=10.
      exec(c_mvi, 3'd0, 3'd0, 16'd11);
      exec(c_mvi, 3'd1, 3'd0, 16'd10);
      exec(c_mv, 3'd0, 3'd1, 16'd0);
      chk("mv_ir_literal", {7'd0, dut.IR.Q}, 16'h0001);
      chk("mv_r0_literal", dut.R0.Q, 16'd10);
      idle();

      // mvi R0,5.
      exec(c_mvi, 3'd0, 3'd1, 16'd5);
      chk("mvi_r0_literal", dut.R0.Q, 16'd5);

      // sub R1,R0: 10 - 5.
      exec(c_sub, 3'd1, 3'd0, 16'd0);
      chk("sub_a_literal", dut.A.Q, 16'd10);
      chk("sub_g_literal", dut.G.Q, 16'd5);
      chk("sub_r1_literal", dut.R1.Q, 16'd5);

      // Clear G via sub Rx,Rx, then mvnz with G=0 must not write.
      exec(c_mvi, 3'd2, 3'd0, 16'd7);
      exec(c_sub, 3'd2, 3'd2, 16'd0);
      chk("subxx_literal", dut.R2.Q, 16'd0);
      exec(c_mvi, 3'd0, 3'd0, 16'd11);
      exec(c_mvi, 3'd1, 3'd0, 16'd10);
      exec(c_mvnz, 3'd0, 3'd1, 16'd0);
      chk("mvnz_g0_literal", dut.R0.Q, 16'd11);

      // G=5, mvnz now writes.
      exec(c_mvi, 3'd4, 3'd0, 16'd8);
      exec(c_mvi, 3'd5, 3'd0, 16'd3);
      exec(c_sub, 3'd4, 3'd5, 16'd0);
      exec(c_mvnz, 3'd0, 3'd1, 16'd0);
      chk("mvnz_g5_literal", dut.R0.Q, 16'd10);

      // No-op and wraparound add.
      exec(c_nop, 3'd3, 3'd4, 16'd0);
      exec(c_mvi, 3'd2, 3'd0, 16'hFFFF);
      exec(c_mvi, 3'd3, 3'd0, 16'd2);
      exec(c_add, 3'd2, 3'd3, 16'd0);
      chk("add_wrap_literal", dut.R2.Q, 16'd1);
      idle();

      // Second add aborted by reset during T2.
      step({7'd0, c_add, 3'd2, 3'd3}, 1'b1, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
      step(16'd0, 1'b0, m_r[2], 1'b0, 1'b1, m_r[2], m_r[3]);
      Resetn = 1'b1;
      step(16'd0, 1'b0, m_r[3], 1'b0, 1'b1, m_r[2], m_r[3]);
      chk("abort_tstep", 16'(dut.r_tstep), 16'd0);
      step(16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
      Resetn = 1'b0;
      model_reset();
      idle();
      check_state();
      chk("abort_r2_literal", dut.R2.Q, 16'd0);

      // Processor still works after the abort.
      exec(c_mvi, 3'd6, 3'd0, 16'h1234);
      exec(c_add, 3'd7, 3'd6, 16'd0);
      chk("post_abort_literal", dut.R7.Q, 16'h1234);

      exp_valid = 1'b0;
      @(posedge Clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/processador_multiciclo.md
Name: processador_multiciclo

Overview:
- Simple multicycle 16-bit processor with eight general registers R0–R7, accumulator A, result register G, a 9-bit instruction register IR, an adder/subtractor and a single shared 16-bit bus.
- Instructions arrive on DIN, are fetched into IR, then execute over 1–3 further clock steps under a 2-bit step counter.
- Sits below a memory/instruction-source wrapper that drives DIN and Run.

Parameters:
- None. Data width is fixed at 16; instruction width is fixed at 9; there are 8 registers.

Ports:
- Clock  in  1  single system clock.
- Resetn  in  1  synchronous, active-high reset, sampled on the rising edge of Clock.
- DIN  in  16  instruction word (bits 8:0) in T0; immediate data during mvi T1.
- Run  in  1  when 1 in T0, fetch and start an instruction.
- Done  out  1  combinational; 1 in the final step of an instruction.
- BusWires  out  16  shared bus value.
- Rx_data  out  16  contents of the register selected by IR[5:3].
- Ry_data  out  16  contents of the register selected by IR[2:0].

Behaviour:
- Instruction format: IR[8:6] = opcode, IR[5:3] = X (destination), IR[2:0] = Y (source).
- Opcodes:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#DIN
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 100 mvnz Rx,Ry
  - 101–111: no-op.
- Tstep (2-bit) updates on the rising edge of Clock:
  - reset → 0;
  - else if Done → 0;
  - else if Tstep = 0 and Run = 0 → hold at 0;
  - else Tstep+1.
- Datapath registers (R0–R7, A, G, IR) capture on the falling edge of Clock when their enable is active, so the bus value selected during step T is stored mid-step T.
- Resetn = 1 at a rising edge also clears all datapath registers to 0 at the following falling edge. It aborts any in-flight instruction; the next step is T0.
- Control signals per step (all combinational from Tstep, IR, G, Run):
  - T0: IRin = Run. Bus is 0.
  - mv, T1: bus = RY; RXin; Done.
  - mvi, T1: bus = DIN; RXin; Done.
  - add/sub, T1: bus = RX; Ain.
  - add/sub, T2: bus = RY; G ← A+bus (add) or A−bus (sub); Gin.
  - add/sub, T3: bus = G; RXin; Done.
  - mvnz, T1: if G ≠ 0 then bus = RY and RXin; Done always.
  - no-op, T1: Done; no write.
- Arithmetic is modulo 2^16; no carry or flags. The G≠0 test uses the full 16-bit G.
- Bus mux priority when no source is enabled: BusWires = 0. Exactly one source is selected otherwise.
- X = Y is legal; sub Rx,Rx yields 0.
- Rx_data and Ry_data are combinational reads of the current IR fields.
- Done is never asserted in T0. Latency is 2 steps for mv/mvi/mvnz/no-op and 4 steps for add/sub.

Decomposition:
- Shared package holds:
  - opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011, OP_MVNZ=3'b100;
  - step constants T0–T3;
  - widths DATA_W=16 and IR_W=9.
- One natural sub-module: regn, an n-bit register with load enable, synchronous clear and output Q. It is instantiated as R0–R7, A, G (n=16) and IR (n=9), with hierarchical names R0..R7, A, G, IR.

Test Plan:
- Reset: hold Resetn=1 for 3 edges, then release with Run=0 → Tstep=0, Done=0, BusWires=0, all registers 0; Tstep stays 0.
- mv R0,R1 (DIN=9'b000_000_001, R0=11, R1=10, Run=1):
  - IR=000000001 after the T0 falling edge;
  - T1: BusWires=10, Done=1; R0=10, R1=10;
  - next step is T0.
- mvi R0,5 (DIN=9'b001_000_001, R0=11): T0 loads IR; at T1 drive DIN=5 → BusWires=5, Done=1, R0=5.
- sub R1,R0 (DIN=9'b011_001_000, R0=5, R1=10):
  - T1 A=10;
  - T2 BusWires=5, G=5;
  - T3 BusWires=5, Done=1, R1=5, R0=5.
- mvnz R0,R1 with G=0 (R0=11, R1=10): T1 Done=1, R0 stays 11. Repeat with G=5 → R0=10.
- add R2,R3 with R2=16'hFFFF, R3=2: after 4 steps R2=1 (wrap). Assert Resetn mid-T2 of a second add → Tstep=0, destination register unchanged by that add.
